// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the fetch-stage branch predictor.
package branch_predictor_pkg;

   // 2-bit saturating direction counter; bit 1 is the taken prediction
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } sat_ctr_t;

   localparam int PHT_IDX_W_DEF = 8;
   localparam int BTB_IDX_W_DEF = 5;
   localparam int GHR_W_DEF     = 8;

   // Next counter value after one resolved outcome; saturates at both ends
   function automatic sat_ctr_t sat_next(input sat_ctr_t c, input logic taken);
      sat_ctr_t r;
      r = c;
      unique case (c)
         SNT: r = taken ? WNT : SNT;
         WNT: r = taken ? WT  : SNT;
         WT:  r = taken ? ST  : WNT;
         ST:  r = taken ? ST  : WT;
         default: r = c;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: combinational read, single write port.
// Only the valid bits are reset; tag/target contents are don't-care until valid.
module branch_predictor_btb
   import branch_predictor_pkg::*;
#(
   parameter int IDX_W = BTB_IDX_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] rd_pc,
   output logic        rd_hit,
   output logic [31:0] rd_target,
   input  logic        we,
   input  logic [31:0] wr_pc,
   input  logic [31:0] wr_target
);

   localparam int TAG_W = 30 - IDX_W;
   localparam int N     = 1 << IDX_W;

   logic [N-1:0]     vld;
   logic [TAG_W-1:0] tag [N];
   logic [31:0]      tgt [N];

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0] rd_tag, wr_tag;

   assign rd_idx = rd_pc[IDX_W+1:2];
   assign rd_tag = rd_pc[31:IDX_W+2];
   assign wr_idx = wr_pc[IDX_W+1:2];
   assign wr_tag = wr_pc[31:IDX_W+2];

   assign rd_hit    = vld[rd_idx] && (tag[rd_idx] == rd_tag);
   assign rd_target = tgt[rd_idx];

   // PCs are word aligned; the byte-offset bits carry no information here
   logic unused_ofs;
   assign unused_ofs = ^{rd_pc[1:0], wr_pc[1:0]};

   // Valid bits: cleared by reset, set on every allocation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  vld         <= '0;
      else if (we) vld[wr_idx] <= 1'b1;
   end

   // Tag/target payload, overwritten on allocation
   always_ff @(posedge clk) begin
      if (we) begin
         tag[wr_idx] <= wr_tag;
         tgt[wr_idx] <= wr_target;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direction predictor (2-bit PHT) plus BTB, trained by EXE.
// Optional gshare indexing with speculative global history is enabled by
// defining BRANCH_PRED_GSHARE_EN; otherwise the predictor is bimodal and
// pred_ghr is tied to zero.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int PHT_IDX_W = PHT_IDX_W_DEF,
   parameter int BTB_IDX_W = BTB_IDX_W_DEF,
   parameter int GHR_W     = GHR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 if_valid,
   input  logic [31:0]          if_pc,
   output logic                 pred_taken,
   output logic [31:0]          pred_target,
   output logic [PHT_IDX_W-1:0] pred_idx,
   output logic [GHR_W-1:0]     pred_ghr,
   input  logic                 ex_valid,
   input  logic [31:0]          ex_pc,
   input  logic                 ex_taken,
   input  logic [31:0]          ex_target,
   input  logic [PHT_IDX_W-1:0] ex_idx,
   input  logic [GHR_W-1:0]     ex_ghr,
   input  logic                 ex_mispredict
);

   localparam int PHT_N = 1 << PHT_IDX_W;

   sat_ctr_t             pht [PHT_N];
   logic                 btb_hit;
   logic [31:0]          btb_target;
   logic [PHT_IDX_W-1:0] lk_idx;

   // Only taken branches allocate; a not-taken outcome leaves the BTB alone
   branch_predictor_btb #(.IDX_W(BTB_IDX_W)) u_btb (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_pc     (if_pc),
      .rd_hit    (btb_hit),
      .rd_target (btb_target),
      .we        (ex_valid && ex_taken),
      .wr_pc     (ex_pc),
      .wr_target (ex_target)
   );

`ifdef BRANCH_PRED_GSHARE_EN
   logic [GHR_W-1:0] ghr;

   assign lk_idx   = if_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
   assign pred_ghr = ghr;

   // Speculative history; a mispredict rebuilds it from the EXE snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     ghr <= '0;
      else if (ex_valid && ex_mispredict) ghr <= {ex_ghr[GHR_W-2:0], ex_taken};
      else if (if_valid && btb_hit)   ghr <= {ghr[GHR_W-2:0], pred_taken};
   end
`else
   assign lk_idx   = if_pc[PHT_IDX_W+1:2];
   assign pred_ghr = '0;

   // History inputs have no consumer in the bimodal build
   logic unused_hist;
   assign unused_hist = ^{if_valid, ex_ghr, ex_mispredict};
`endif

   // Lookup reads flop state only, so a same-cycle update is seen next cycle
   assign pred_idx    = lk_idx;
   assign pred_taken  = btb_hit && pht[lk_idx][1];
   assign pred_target = pred_taken ? btb_target : (if_pc + 32'd4);

   // Direction counters: reset to weakly-not-taken, trained by EXE outcome
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PHT_N; i++) pht[i] <= WNT;
      end else if (ex_valid) begin
         pht[ex_idx] <= sat_next(pht[ex_idx], ex_taken);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor with a table-level model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [7:0]  pred_idx;
   logic [7:0]  pred_ghr;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic [7:0]  ex_idx;
   logic [7:0]  ex_ghr;
   logic        ex_mispredict;

   int total = 0;
   int bad   = 0;

   // reference state: counters as ints 0..3, BTB as plain arrays
   int          m_pht [256];
   bit          m_val [32];
   bit [24:0]   m_tag [32];
   bit [31:0]   m_tgt [32];
   int          m_ghr;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_idx      (pred_idx),
      .pred_ghr      (pred_ghr),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_idx        (ex_idx),
      .ex_ghr        (ex_ghr),
      .ex_mispredict (ex_mispredict)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      for (int i = 0; i < 32; i++) m_val[i] = 0;
      m_ghr = 0;
   endfunction

   function automatic void m_pred(input logic [31:0] pc, output bit hit, output bit tk,
                                  output logic [31:0] tg, output logic [7:0] ix);
      int b;
      b   = (pc / 4) % 32;
      hit = m_val[b] && (m_tag[b] == pc[31:7]);
`ifdef BRANCH_PRED_GSHARE_EN
      ix  = 8'((pc / 4) % 256) ^ 8'(m_ghr);
`else
      ix  = 8'((pc / 4) % 256);
`endif
      tk  = hit && (m_pht[ix] >= 2);
      tg  = tk ? m_tgt[b] : pc + 32'd4;
   endfunction

   // model of one clock edge, using the inputs held across it
   function automatic void m_edge();
      bit hit, tk; logic [31:0] tg; logic [7:0] ix; int b;
      m_pred(if_pc, hit, tk, tg, ix);
      if (ex_valid) begin
         if (ex_taken) m_pht[ex_idx] = (m_pht[ex_idx] == 3) ? 3 : m_pht[ex_idx] + 1;
         else          m_pht[ex_idx] = (m_pht[ex_idx] == 0) ? 0 : m_pht[ex_idx] - 1;
         if (ex_taken) begin
            b = (ex_pc / 4) % 32;
            m_val[b] = 1; m_tag[b] = ex_pc[31:7]; m_tgt[b] = ex_target;
         end
      end
`ifdef BRANCH_PRED_GSHARE_EN
      if (ex_valid && ex_mispredict) m_ghr = ((int'(ex_ghr) * 2) + int'(ex_taken)) % 256;
      else if (if_valid && hit)      m_ghr = ((m_ghr * 2) + int'(tk)) % 256;
`endif
   endfunction

   // compare at the falling edge, then let one rising edge happen
   task automatic step(input bit xc, input bit x_tk, input logic [31:0] x_tgt);
      bit hit, tk; logic [31:0] tg; logic [7:0] ix;
      @(negedge clk);
      m_pred(if_pc, hit, tk, tg, ix);
      chk("pred_taken", pred_taken, tk);
      chk("pred_target", pred_target, tg);
      chk("pred_idx", pred_idx, ix);
      chk("pred_ghr", pred_ghr, 8'(m_ghr));
      if (xc) begin
         chk("plan_taken", pred_taken, x_tk);
         chk("plan_target", pred_target, x_tgt);
      end
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic set_ex(input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tg, input logic [7:0] ix,
                         input logic [7:0] gh, input bit mp);
      ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tg;
      ex_idx = ix; ex_ghr = gh; ex_mispredict = mp;
   endtask

   function automatic logic [31:0] pick_pc();
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: return 32'h100 + 32'($urandom_range(0, 5)) * 4;
         6:       return 32'h180;
         7:       return 32'h1180;
         8:       return 32'hFFFF_FFFC;
         default: return $urandom & 32'hFFFF_FFFC;
      endcase
   endfunction

   initial begin
      logic [31:0] p;
      rst_n = 1'b0; if_valid = 1'b0; if_pc = 32'h60;
      set_ex(0, 0, 0, 0, 0, 0, 0);
      m_reset();
      #3;
      chk("rst_taken", pred_taken, 0);
      chk("rst_target", pred_target, 32'h64);
      chk("rst_ghr", pred_ghr, 0);
      #10 rst_n = 1'b1;

      step(1, 0, 32'h64);
      // first taken training: miss this cycle, hit with counter 10 next
      if_valid = 1'b1; if_pc = 32'h100;
      set_ex(1, 32'h100, 1, 32'h200, 8'h40, 0, 1);
`ifdef BRANCH_PRED_GSHARE_EN
      step(0, 0, 0);
      set_ex(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0);
`else
      step(1, 0, 32'h104);
      set_ex(0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 32'h200);
      // saturate at 11, then walk down to 00
      set_ex(1, 32'h100, 1, 32'h200, 8'h40, 0, 0);
      repeat (3) step(1, 1, 32'h200);
      set_ex(1, 32'h100, 0, 32'h0, 8'h40, 0, 0);
      step(1, 1, 32'h200);
      set_ex(0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 32'h200);
      set_ex(1, 32'h100, 0, 32'h0, 8'h40, 0, 0);
      step(1, 1, 32'h200);
      step(1, 0, 32'h104);
      set_ex(0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 32'h104);
      // collision: counter 00 -> 01 -> 10, lookup sees the old value
      set_ex(1, 32'h100, 1, 32'h200, 8'h40, 0, 0);
      step(1, 0, 32'h104);
      step(1, 0, 32'h104);
      set_ex(0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 32'h200);
`endif
      // wrap of the sequential next PC
      if_pc = 32'hFFFF_FFFC;
      step(1, 0, 32'h0);

`ifdef BRANCH_PRED_GSHARE_EN
      // set GHR to 0x0F via repair, train PHT[0x40^0x0F], then repair again
      // in the same cycle as a taken-predicting hit
      if_valid = 1'b0;
      set_ex(1, 32'h100, 1, 32'h200, 8'h4F, 8'h07, 1);
      step(0, 0, 0);
      set_ex(1, 32'h100, 1, 32'h200, 8'h4F, 8'h07, 0);
      step(0, 0, 0);
      @(negedge clk);
      chk("gs_ghr_pre", pred_ghr, 8'h0F);
      if_valid = 1'b1; if_pc = 32'h100;
      set_ex(1, 32'h100, 0, 32'h0, 8'h11, 8'h03, 1);
      step(1, 1, 32'h200);
      set_ex(0, 0, 0, 0, 0, 0, 0);
      if_valid = 1'b0;
      chk("gs_ghr_repair", pred_ghr, 8'h06);
`endif

      for (int i = 0; i < 400; i++) begin
         if_valid = ($urandom_range(0, 3) != 0);
         if_pc    = pick_pc();
         p        = pick_pc();
         set_ex($urandom_range(0, 1), p, $urandom_range(0, 1),
                $urandom & 32'hFFFF_FFFC,
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : p[9:2],
                8'($urandom), $urandom_range(0, 1));
         step(0, 0, 0);
         if (i == 200) begin
            // asynchronous reset mid-stream drops all training at once
            rst_n = 1'b0;
            #1;
            chk("mid_rst_taken", pred_taken, 0);
            chk("mid_rst_ghr", pred_ghr, 0);
            chk("mid_rst_target", pred_target, if_pc + 32'd4);
            m_reset();
            if_pc = 32'h100;
            #1;
            chk("mid_rst_taken_100", pred_taken, 0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
